// File: rtl/alu_exec_stage.sv
// alu_exec_stage: handshaked MIPS execute stage.
//
// Decodes the instruction word and produces, in one cycle, the ALU result,
// load/store effective address, or branch/jump decision and target. An
// optional iterative multiply/divide unit (one bit per cycle) owns HI/LO and
// stalls the stage while it runs.
//
// Ports:
//   clock, reset_n             clock, asynchronous active-low reset
//   in_valid / in_ready        upstream handshake
//   in_insn                    32-bit instruction word
//   in_rs_data, in_rt_data     operand values
//   in_pc                      address of the instruction
//   out_valid / out_ready      downstream handshake
//   out_data                   ALU result, effective address or taken target
//   out_bt                     branch/jump taken
//   out_insn, out_rt_data      registered instruction and store data
//   md_busy                    multiply/divide in progress
module alu_exec_stage #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          MD_ENABLE = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_insn,
    input  logic [WIDTH-1:0] in_rs_data,
    input  logic [WIDTH-1:0] in_rt_data,
    input  logic [WIDTH-1:0] in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_bt,
    output logic [31:0]      out_insn,
    output logic [WIDTH-1:0] out_rt_data,
    output logic             md_busy
);

    localparam int unsigned CntW = $clog2(WIDTH);

    // Opcodes
    localparam logic [5:0] OpSpecial = 6'h00;
    localparam logic [5:0] OpRegimm  = 6'h01;
    localparam logic [5:0] OpJ       = 6'h02;
    localparam logic [5:0] OpBeq     = 6'h04;
    localparam logic [5:0] OpBne     = 6'h05;
    localparam logic [5:0] OpBlez    = 6'h06;
    localparam logic [5:0] OpBgtz    = 6'h07;
    localparam logic [5:0] OpAddiu   = 6'h09;
    localparam logic [5:0] OpSlti    = 6'h0A;
    localparam logic [5:0] OpOri     = 6'h0D;
    localparam logic [5:0] OpLui     = 6'h0F;
    localparam logic [5:0] OpLw      = 6'h23;
    localparam logic [5:0] OpSw      = 6'h2B;

    // R-type functs
    localparam logic [5:0] FnSll   = 6'h00;
    localparam logic [5:0] FnSrl   = 6'h02;
    localparam logic [5:0] FnSra   = 6'h03;
    localparam logic [5:0] FnMfhi  = 6'h10;
    localparam logic [5:0] FnMflo  = 6'h12;
    localparam logic [5:0] FnMult  = 6'h18;
    localparam logic [5:0] FnMultu = 6'h19;
    localparam logic [5:0] FnDiv   = 6'h1A;
    localparam logic [5:0] FnDivu  = 6'h1B;
    localparam logic [5:0] FnAdd   = 6'h20;
    localparam logic [5:0] FnAddu  = 6'h21;
    localparam logic [5:0] FnSub   = 6'h22;
    localparam logic [5:0] FnSubu  = 6'h23;
    localparam logic [5:0] FnAnd   = 6'h24;
    localparam logic [5:0] FnOr    = 6'h25;
    localparam logic [5:0] FnXor   = 6'h26;
    localparam logic [5:0] FnNor   = 6'h27;
    localparam logic [5:0] FnSlt   = 6'h2A;
    localparam logic [5:0] FnSltu  = 6'h2B;

    typedef enum logic [1:0] {StIdle, StRun, StDone} md_state_e;

    // ------------------------------------------------------------------
    // Field decode
    // ------------------------------------------------------------------
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [4:0]       rt_f;
    logic [4:0]       shamt;
    logic [15:0]      imm;
    logic [25:0]      index;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] imm_zext;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] j_target;
    logic             rs_neg;
    logic             rs_zero;

    assign opcode    = in_insn[31:26];
    assign rt_f      = in_insn[20:16];
    assign shamt     = in_insn[10:6];
    assign funct     = in_insn[5:0];
    assign imm       = in_insn[15:0];
    assign index     = in_insn[25:0];
    assign imm_sext  = {{(WIDTH-16){imm[15]}}, imm};
    assign imm_zext  = {{(WIDTH-16){1'b0}}, imm};
    assign pc_plus4  = in_pc + WIDTH'(4);
    assign br_target = pc_plus4 + (imm_sext << 2);
    assign j_target  = {pc_plus4[WIDTH-1:28], index, 2'b00};
    assign rs_neg    = in_rs_data[WIDTH-1];
    assign rs_zero   = (in_rs_data == '0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    md_state_e        md_state_q, md_state_d;
    logic [CntW-1:0]  md_cnt_q, md_cnt_d;
    logic [WIDTH-1:0] md_acc_q;   // product high half / partial remainder
    logic [WIDTH-1:0] md_sh_q;    // product low half / dividend-quotient shifter
    logic [WIDTH-1:0] md_opb_q;   // |multiplicand| or |divisor|
    logic [WIDTH-1:0] md_opa_q;   // original dividend, for divide-by-zero HI
    logic             md_div_q;
    logic             md_neg_q;   // negate product / quotient at the end
    logic             md_neg_rem_q;
    logic             md_zero_q;
    logic [31:0]      md_insn_q;
    logic [WIDTH-1:0] md_rt_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_bt_q;
    logic [31:0]      out_insn_q;
    logic [WIDTH-1:0] out_rt_q;

    logic accept;
    logic md_start;
    logic md_load;
    logic md_step;
    logic hilo_we;

    assign md_busy   = (md_state_q != StIdle);
    assign in_ready  = !md_busy && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign md_load   = accept && md_start;
    assign md_step   = (md_state_q == StRun);

    // ------------------------------------------------------------------
    // Multiply/divide datapath
    // ------------------------------------------------------------------
    logic             op_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;

    // funct[0] clear selects the signed variants (MULT, DIV).
    assign op_signed = !funct[0];
    assign a_neg     = op_signed && in_rs_data[WIDTH-1];
    assign b_neg     = op_signed && in_rt_data[WIDTH-1];
    assign abs_a     = a_neg ? -in_rs_data : in_rs_data;
    assign abs_b     = b_neg ? -in_rt_data : in_rt_data;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shv;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [WIDTH-1:0] step_acc, step_sh;

    always_comb begin
        // Shift-add: add multiplicand on the low multiplier bit, then shift right.
        mul_sum = {1'b0, md_acc_q} + (md_sh_q[0] ? {1'b0, md_opb_q} : '0);
        // Restoring divide: shift in next dividend bit, subtract if it fits.
        div_shv = {md_acc_q, md_sh_q[WIDTH-1]};
        div_ge  = (div_shv >= {1'b0, md_opb_q});
        div_sub = div_shv[WIDTH-1:0] - md_opb_q;
        if (md_div_q) begin
            step_acc = div_ge ? div_sub : div_shv[WIDTH-1:0];
            step_sh  = {md_sh_q[WIDTH-2:0], div_ge};
        end else begin
            step_acc = mul_sum[WIDTH:1];
            step_sh  = {mul_sum[0], md_sh_q[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] mul_full, mul_signed;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   md_hi, md_lo;

    always_comb begin
        mul_full   = {md_acc_q, md_sh_q};
        mul_signed = md_neg_q ? -mul_full : mul_full;
        quo        = md_neg_q ? -md_sh_q : md_sh_q;
        rem        = md_neg_rem_q ? -md_acc_q : md_acc_q;
        if (md_div_q) begin
            if (md_zero_q) begin
                md_lo = '1;
                md_hi = md_opa_q;
            end else begin
                md_lo = quo;
                md_hi = rem;
            end
        end else begin
            md_hi = mul_signed[2*WIDTH-1:WIDTH];
            md_lo = mul_signed[WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Multiply/divide FSM
    // ------------------------------------------------------------------
    always_comb begin
        md_state_d = md_state_q;
        md_cnt_d   = md_cnt_q;
        hilo_we    = 1'b0;
        case (md_state_q)
            StIdle: begin
                if (md_load) begin
                    md_state_d = StRun;
                    md_cnt_d   = '0;
                end
            end
            StRun: begin
                md_cnt_d = md_cnt_q + CntW'(1);
                if (md_cnt_q == CntW'(WIDTH - 1)) begin
                    md_state_d = StDone;
                end
            end
            StDone: begin
                // Wait while the output register still holds an unconsumed result.
                if (!out_valid_q || out_ready) begin
                    hilo_we    = 1'b1;
                    md_state_d = StIdle;
                end
            end
            default: md_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            md_state_q   <= StIdle;
            md_cnt_q     <= '0;
            md_acc_q     <= '0;
            md_sh_q      <= '0;
            md_opb_q     <= '0;
            md_opa_q     <= '0;
            md_div_q     <= 1'b0;
            md_neg_q     <= 1'b0;
            md_neg_rem_q <= 1'b0;
            md_zero_q    <= 1'b0;
            md_insn_q    <= '0;
            md_rt_q      <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
        end else begin
            md_state_q <= md_state_d;
            md_cnt_q   <= md_cnt_d;
            if (md_load) begin
                md_acc_q     <= '0;
                md_sh_q      <= abs_a;
                md_opb_q     <= abs_b;
                md_opa_q     <= in_rs_data;
                md_div_q     <= funct[1];
                md_neg_q     <= a_neg ^ b_neg;
                md_neg_rem_q <= a_neg;
                md_zero_q    <= (in_rt_data == '0);
                md_insn_q    <= in_insn;
                md_rt_q      <= in_rt_data;
            end else if (md_step) begin
                md_acc_q <= step_acc;
                md_sh_q  <= step_sh;
            end
            if (hilo_we) begin
                hi_q <= md_hi;
                lo_q <= md_lo;
            end
        end
    end

    // MFHI/MFLO see values being written this cycle.
    logic [WIDTH-1:0] hi_fwd, lo_fwd;
    assign hi_fwd = hilo_we ? md_hi : hi_q;
    assign lo_fwd = hilo_we ? md_lo : lo_q;

    // ------------------------------------------------------------------
    // Single-cycle ALU / branch unit
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] alu_result;
    logic             alu_bt;
    logic             br_taken;

    always_comb begin
        alu_result = '0;
        alu_bt     = 1'b0;
        br_taken   = 1'b0;
        md_start   = 1'b0;
        case (opcode)
            OpSpecial: begin
                case (funct)
                    FnAdd, FnAddu: alu_result = in_rs_data + in_rt_data;
                    FnSub, FnSubu: alu_result = in_rs_data - in_rt_data;
                    FnAnd:  alu_result = in_rs_data & in_rt_data;
                    FnOr:   alu_result = in_rs_data | in_rt_data;
                    FnXor:  alu_result = in_rs_data ^ in_rt_data;
                    FnNor:  alu_result = ~(in_rs_data | in_rt_data);
                    FnSlt:  alu_result = {{(WIDTH-1){1'b0}},
                                          $signed(in_rs_data) < $signed(in_rt_data)};
                    FnSltu: alu_result = {{(WIDTH-1){1'b0}}, in_rs_data < in_rt_data};
                    FnSll:  alu_result = in_rt_data << shamt;
                    FnSrl:  alu_result = in_rt_data >> shamt;
                    FnSra:  alu_result = $signed(in_rt_data) >>> shamt;
                    FnMfhi: alu_result = MD_ENABLE ? hi_fwd : '0;
                    FnMflo: alu_result = MD_ENABLE ? lo_fwd : '0;
                    FnMult, FnMultu, FnDiv, FnDivu: md_start = MD_ENABLE;
                    default: ;
                endcase
            end
            OpAddiu, OpLw, OpSw: alu_result = in_rs_data + imm_sext;
            OpSlti: alu_result = {{(WIDTH-1){1'b0}}, $signed(in_rs_data) < $signed(imm_sext)};
            OpOri:  alu_result = in_rs_data | imm_zext;
            OpLui:  alu_result = imm_sext << 16;
            OpBeq:  br_taken = (in_rs_data == in_rt_data);
            OpBne:  br_taken = (in_rs_data != in_rt_data);
            OpBlez: br_taken = rs_neg || rs_zero;
            OpBgtz: br_taken = !rs_neg && !rs_zero;
            OpRegimm: begin
                if (rt_f == 5'd0) begin
                    br_taken = rs_neg;
                end else if (rt_f == 5'd1) begin
                    br_taken = !rs_neg;
                end
            end
            OpJ: begin
                alu_bt     = 1'b1;
                alu_result = j_target;
            end
            default: ;
        endcase
        // Not-taken branches leave result 0.
        if (br_taken) begin
            alu_bt     = 1'b1;
            alu_result = br_target;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_bt_q    <= 1'b0;
            out_insn_q  <= '0;
            out_rt_q    <= '0;
        end else if (accept && !md_start) begin
            out_valid_q <= 1'b1;
            out_data_q  <= alu_result;
            out_bt_q    <= alu_bt;
            out_insn_q  <= in_insn;
            out_rt_q    <= in_rt_data;
        end else if (hilo_we) begin
            out_valid_q <= 1'b1;
            out_data_q  <= md_lo;
            out_bt_q    <= 1'b0;
            out_insn_q  <= md_insn_q;
            out_rt_q    <= md_rt_q;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_bt      = out_bt_q;
    assign out_insn    = out_insn_q;
    assign out_rt_data = out_rt_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage (WIDTH = 32, MD_ENABLE = 1).
// A behavioural model predicts every output from the instruction semantics;
// a negedge monitor checks the output stream against it every valid cycle.
module tb_alu_exec_stage;

    localparam int unsigned W = 32;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_insn = '0;
    logic [31:0] in_rs_data = '0;
    logic [31:0] in_rt_data = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_bt;
    logic [31:0] out_insn;
    logic [31:0] out_rt_data;
    logic        md_busy;

    alu_exec_stage #(.WIDTH(W), .MD_ENABLE(1'b1)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_insn     (in_insn),
        .in_rs_data  (in_rs_data),
        .in_rt_data  (in_rt_data),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_bt      (out_bt),
        .out_insn    (out_insn),
        .out_rt_data (out_rt_data),
        .md_busy     (md_busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] data;
        logic        bt;
        logic [31:0] insn;
        logic [31:0] rt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          n_total = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sa);
        return {6'h00, 5'd1, 5'd2, 5'd3, sa, fn};
    endfunction
    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, 5'd1, rt, imm};
    endfunction

    // ---------------- behavioural model ----------------
    function automatic logic [63:0] md_model(input logic [31:0] insn, input logic [31:0] rs,
                                             input logic [31:0] rt);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        int          si, ti;
        p = '0;
        case (insn[5:0])
            6'h18: begin
                sa = $signed(rs);
                sb = $signed(rt);
                p  = sa * sb;
            end
            6'h19: begin
                ua = {32'h0, rs};
                ub = {32'h0, rt};
                p  = ua * ub;
            end
            6'h1A: begin
                si = rs;
                ti = rt;
                if (rt == 0) p = {rs, 32'hFFFF_FFFF};
                else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) p = {32'h0, 32'h8000_0000};
                else p = {32'(si % ti), 32'(si / ti)};
            end
            default: begin
                if (rt == 0) p = {rs, 32'hFFFF_FFFF};
                else p = {rs % rt, rs / rt};
            end
        endcase
        return p;
    endfunction

    function automatic exp_t model(input logic [31:0] insn, input logic [31:0] rs,
                                   input logic [31:0] rt, input logic [31:0] pc,
                                   input logic [31:0] hi, input logic [31:0] lo);
        exp_t        e;
        logic [5:0]  op, fn;
        logic [4:0]  sa;
        logic [31:0] se, p4, tgt;
        logic        tk;
        op  = insn[31:26];
        fn  = insn[5:0];
        sa  = insn[10:6];
        se  = {{16{insn[15]}}, insn[15:0]};
        p4  = pc + 4;
        tgt = p4 + se * 4;
        tk  = 1'b0;
        e.data = '0;
        e.bt   = 1'b0;
        e.insn = insn;
        e.rt   = rt;
        case (op)
            6'h00: case (fn)
                6'h20, 6'h21: e.data = rs + rt;
                6'h22, 6'h23: e.data = rs - rt;
                6'h24: e.data = rs & rt;
                6'h25: e.data = rs | rt;
                6'h26: e.data = rs ^ rt;
                6'h27: e.data = ~(rs | rt);
                6'h2A: e.data = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
                6'h2B: e.data = (rs < rt) ? 32'd1 : 32'd0;
                6'h00: e.data = rt << sa;
                6'h02: e.data = rt >> sa;
                6'h03: e.data = $signed(rt) >>> sa;
                6'h10: e.data = hi;
                6'h12: e.data = lo;
                6'h18, 6'h19, 6'h1A, 6'h1B: e.data = lo;
                default: ;
            endcase
            6'h09, 6'h23, 6'h2B: e.data = rs + se;
            6'h0A: e.data = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0;
            6'h0D: e.data = rs | {16'h0, insn[15:0]};
            6'h0F: e.data = {insn[15:0], 16'h0};
            6'h04: tk = (rs == rt);
            6'h05: tk = (rs != rt);
            6'h06: tk = ($signed(rs) <= 0);
            6'h07: tk = ($signed(rs) > 0);
            6'h01: begin
                if (insn[20:16] == 5'd0) tk = ($signed(rs) < 0);
                else if (insn[20:16] == 5'd1) tk = ($signed(rs) >= 0);
            end
            6'h02: begin
                e.bt   = 1'b1;
                e.data = {p4[31:28], insn[25:0], 2'b00};
            end
            default: ;
        endcase
        if (op == 6'h01 || (op >= 6'h04 && op <= 6'h07)) begin
            e.bt   = tk;
            e.data = tk ? tgt : 32'h0;
        end
        return e;
    endfunction

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                exp_q.delete();
                m_hi = '0;
                m_lo = '0;
            end else begin
                if (out_valid) begin
                    check("out_has_expect", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        check("out_stream", {out_data, out_bt, out_insn, out_rt_data}, exp_q[0]);
                        if (out_ready) void'(exp_q.pop_front());
                        else check("hold_in_ready", in_ready, 0);
                    end
                end
                if (in_valid && in_ready) begin
                    if (in_insn[31:26] == 6'h00 && in_insn[5:0] >= 6'h18 && in_insn[5:0] <= 6'h1B)
                        {m_hi, m_lo} = md_model(in_insn, in_rs_data, in_rt_data);
                    exp_q.push_back(model(in_insn, in_rs_data, in_rt_data, in_pc, m_hi, m_lo));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [31:0] insn, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] pc);
        int n;
        bit acc;
        in_insn    = insn;
        in_rs_data = rs;
        in_rt_data = rt;
        in_pc      = pc;
        in_valid   = 1'b1;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 300) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            n++;
        end
        in_valid = 1'b0;
        check("accepted", acc, 1);
    endtask

    task automatic issue_expect(input string name, input logic [31:0] insn,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] pc, input logic [31:0] want_data,
                                input logic want_bt);
        issue(insn, rs, rt, pc);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_data"}, out_data, want_data);
        check({name, "_bt"}, out_bt, want_bt);
    endtask

    task automatic md_expect(input string name, input logic [31:0] insn,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input logic [31:0] want_lo);
        int cyc;
        issue(insn, rs, rt, 32'h0);
        check({name, "_busy"}, md_busy, 1);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check({name, "_latency"}, cyc, W + 1);
        check({name, "_lo"}, out_data, want_lo);
        check({name, "_bt"}, out_bt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_bt", out_bt, 0);
        check("rst_out_insn", out_insn, 0);
        check("rst_out_rt", out_rt_data, 0);
        check("rst_md_busy", md_busy, 0);
        check("rst_in_ready", in_ready, 1);

        issue_expect("add_ovf", rtype(6'h20, 0), 32'h7FFF_FFFF, 32'h1, 0, 32'h8000_0000, 0);
        issue_expect("slt", rtype(6'h2A, 0), 32'hFFFF_FFFF, 32'h1, 0, 32'h1, 0);
        issue_expect("sltu", rtype(6'h2B, 0), 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 0);
        issue_expect("sub", rtype(6'h22, 0), 32'd3, 32'd5, 0, 32'hFFFF_FFFE, 0);
        issue_expect("nor", rtype(6'h27, 0), 32'h0, 32'h0, 0, 32'hFFFF_FFFF, 0);
        issue_expect("sra", rtype(6'h03, 5'd4), 32'h0, 32'h8000_0000, 0, 32'hF800_0000, 0);
        issue_expect("srl", rtype(6'h02, 5'd4), 32'h0, 32'h8000_0000, 0, 32'h0800_0000, 0);
        issue_expect("sll", rtype(6'h00, 5'd4), 32'h0, 32'h0000_000F, 0, 32'h0000_00F0, 0);
        issue_expect("beq", itype(6'h04, 5'd2, 16'hFFFF), 32'd5, 32'd5, 32'h100, 32'h100, 1);
        issue_expect("bne", itype(6'h05, 5'd2, 16'hFFFF), 32'd5, 32'd5, 32'h100, 32'h0, 0);
        issue_expect("blez", itype(6'h06, 5'd0, 16'hFFFF), 32'd0, 32'd0, 32'h100, 32'h100, 1);
        issue_expect("bgtz", itype(6'h07, 5'd0, 16'hFFFF), 32'd0, 32'd0, 32'h100, 32'h0, 0);
        issue_expect("bltz", itype(6'h01, 5'd0, 16'h0010), 32'hFFFF_FFFF, 0, 32'h200, 32'h244, 1);
        issue_expect("bgez", itype(6'h01, 5'd1, 16'h0010), 32'hFFFF_FFFF, 0, 32'h200, 32'h0, 0);
        issue_expect("j", {6'h02, 26'h000_0040}, 0, 0, 32'hF000_0000, 32'hF000_0100, 1);
        issue_expect("lui", itype(6'h0F, 5'd0, 16'h1234), 0, 0, 0, 32'h1234_0000, 0);
        issue_expect("ori", itype(6'h0D, 5'd0, 16'h00F0), 32'hFFFF_0000, 0, 0, 32'hFFFF_00F0, 0);
        issue_expect("addiu", itype(6'h09, 5'd0, 16'hFFFF), 32'h10, 0, 0, 32'h0F, 0);
        issue_expect("slti", itype(6'h0A, 5'd0, 16'hFFFE), 32'hFFFF_FFFB, 0, 0, 32'h1, 0);
        issue_expect("lw", itype(6'h23, 5'd0, 16'hFFFC), 32'h1000, 0, 0, 32'h0FFC, 0);
        issue_expect("bad_op", itype(6'h3F, 5'd0, 16'h1234), 32'h55, 32'h66, 0, 32'h0, 0);
        issue_expect("bad_fn", rtype(6'h3F, 0), 32'h55, 32'h66, 0, 32'h0, 0);

        // MULT -3 x 7 with an MFHI waiting behind it
        issue(rtype(6'h18, 0), 32'hFFFF_FFFD, 32'd7, 0);
        check("mult_busy", md_busy, 1);
        in_insn    = rtype(6'h10, 0);
        in_rs_data = '0;
        in_rt_data = '0;
        in_valid   = 1'b1;
        check("mfhi_stalled", in_ready, 0);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check("mult_latency", cyc, W + 1);
        check("mult_lo", out_data, 32'hFFFF_FFEB);
        check("mult_busy_clr", md_busy, 0);
        issue_expect("mult_mfhi", rtype(6'h10, 0), 0, 0, 0, 32'hFFFF_FFFF, 0);
        issue_expect("mult_mflo", rtype(6'h12, 0), 0, 0, 0, 32'hFFFF_FFEB, 0);

        md_expect("div", rtype(6'h1A, 0), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        issue_expect("div_mfhi", rtype(6'h10, 0), 0, 0, 0, 32'hFFFF_FFFF, 0);
        md_expect("div_nd", rtype(6'h1A, 0), 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        issue_expect("div_nd_mfhi", rtype(6'h10, 0), 0, 0, 0, 32'h1, 0);
        md_expect("divu0", rtype(6'h1B, 0), 32'd9, 32'd0, 32'hFFFF_FFFF);
        issue_expect("divu0_mfhi", rtype(6'h10, 0), 0, 0, 0, 32'd9, 0);
        md_expect("divmin", rtype(6'h1A, 0), 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        issue_expect("divmin_mfhi", rtype(6'h10, 0), 0, 0, 0, 32'h0, 0);
        md_expect("multu", rtype(6'h19, 0), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
        issue_expect("multu_mfhi", rtype(6'h10, 0), 0, 0, 0, 32'hFFFF_FFFE, 0);

        // Stream of ADDIUs with downstream stalled for three cycles
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    issue(itype(6'h09, 5'd0, 16'(i + 1)), 32'h1000, 32'(i), 0);
                end
            end
            begin
                @(posedge clock);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clock);
                    check("hold_data", out_data, 32'h1001);
                    check("hold_ready", in_ready, 0);
                end
                @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (2) @(posedge clock);
        #1;
        check("stream_drained", exp_q.size(), 0);

        // Reset in the middle of a DIV
        issue(rtype(6'h1A, 0), 32'd100, 32'd7, 0);
        repeat (9) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("rstmid_busy", md_busy, 0);
        check("rstmid_valid", out_valid, 0);
        check("rstmid_data", out_data, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        issue_expect("rstmid_mfhi", rtype(6'h10, 0), 0, 0, 0, 32'h0, 0);
        issue_expect("rstmid_mflo", rtype(6'h12, 0), 0, 0, 0, 32'h0, 0);
        issue_expect("rstmid_add", rtype(6'h21, 0), 32'd2, 32'd3, 0, 32'd5, 0);

        repeat (3) @(posedge clock);
        #1;
        check("final_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
